// File: rtl/dht11_reader_if.sv
// dht11_reader_if -- reading/control bus between a dht11_reader and its consumer.
//   start       : one-cycle read request (consumer -> reader)
//   busy        : reader is mid-transaction
//   data_valid  : sticky, at least one good reading has been captured
//   new_data    : one-cycle pulse, sensor_data takes a new value on the next edge
//   sensor_data : {hum_int, hum_dec, temp_int, temp_dec}
//   chk_err     : one-cycle pulse on checksum mismatch
//   tmo_err     : one-cycle pulse on an edge-wait timeout
interface dht11_reader_if;
  logic        start;
  logic        busy;
  logic        data_valid;
  logic        new_data;
  logic [31:0] sensor_data;
  logic        chk_err;
  logic        tmo_err;

  modport master (
    output start,
    input  busy, data_valid, new_data, sensor_data, chk_err, tmo_err
  );

  modport slave (
    input  start,
    output busy, data_valid, new_data, sensor_data, chk_err, tmo_err
  );
endinterface

// File: rtl/dht11_reader.sv
// dht11_reader -- single-wire DHT11 transaction engine for one sensor.
// Issues the host start pulse, times the sensor response, samples 40 bits
// MSB-first, verifies the 8-bit checksum and presents a 32-bit reading.
// Ports:
//   clk      : system clock
//   reset_n  : synchronous, active-low reset
//   dht_in   : raw pad input (asynchronous, synchronised internally)
//   dht_oe   : 1 = pull the line low, 0 = release
//   bus      : slave side of dht11_reader_if (start/busy/reading/error pulses)
module dht11_reader #(
  parameter int unsigned CLK_FREQ       = 12000000,
  parameter int unsigned START_LOW_US   = 18000,
  parameter int unsigned AUTO_PERIOD_US = 2000000,
  parameter int unsigned BIT_THRESH_US  = 48,
  parameter int unsigned TIMEOUT_US     = 200
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           dht_in,
  output logic           dht_oe,
  dht11_reader_if.slave  bus
);

  localparam int unsigned DIV = (CLK_FREQ >= 2000000) ? (CLK_FREQ / 1000000) : 1;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] P_LAST   = PW'(DIV - 1);
  localparam logic [20:0]   T_START  = 21'(START_LOW_US);
  localparam logic [20:0]   T_AUTO   = 21'(AUTO_PERIOD_US);
  localparam logic [20:0]   T_THRESH = 21'(BIT_THRESH_US);
  localparam logic [20:0]   T_TMO    = 21'(TIMEOUT_US);

  typedef enum logic [2:0] {
    S_IDLE, S_START_LOW, S_WAIT_RESP, S_RESP_LOW,
    S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_CHECK
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, line_q, line_prev_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [20:0]   us_q, us_d;
  logic [39:0]   shreg_q, shreg_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;

  logic          tick, rise, fall, timed_wait, tmo_hit, auto_fire, bit_val, sum_ok;
  logic [20:0]   us_inc;
  logic [7:0]    byte_sum;

  assign tick = (presc_q == P_LAST);
  // Limits are compared against the count this cycle's tick produces, so a
  // state lasting N us leaves after exactly N*DIV cycles and bit high times
  // measure at their true length despite the synchroniser latency.
  assign us_inc = (tick && (us_q != '1)) ? us_q + 21'd1 : us_q;
  assign rise   = line_q & ~line_prev_q;
  assign fall   = ~line_q & line_prev_q;

  assign timed_wait = (state_q == S_WAIT_RESP) || (state_q == S_RESP_LOW) ||
                      (state_q == S_RESP_HIGH) || (state_q == S_BIT_LOW)  ||
                      (state_q == S_BIT_HIGH);
  assign tmo_hit   = timed_wait && (us_inc >= T_TMO);
  assign auto_fire = (AUTO_PERIOD_US != 0) && (us_inc >= T_AUTO);
  assign bit_val   = (us_inc > T_THRESH);
  assign byte_sum  = shreg_q[39:32] + shreg_q[31:24] + shreg_q[23:16] + shreg_q[15:8];
  assign sum_ok    = (byte_sum == shreg_q[7:0]);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (bus.start || auto_fire) state_d = S_START_LOW;
      S_START_LOW: if (us_inc >= T_START) state_d = S_WAIT_RESP;
      S_WAIT_RESP: if (tmo_hit) state_d = S_IDLE; else if (fall) state_d = S_RESP_LOW;
      S_RESP_LOW:  if (tmo_hit) state_d = S_IDLE; else if (rise) state_d = S_RESP_HIGH;
      S_RESP_HIGH: if (tmo_hit) state_d = S_IDLE; else if (fall) state_d = S_BIT_LOW;
      S_BIT_LOW:   if (tmo_hit) state_d = S_IDLE; else if (rise) state_d = S_BIT_HIGH;
      S_BIT_HIGH: begin
        if (tmo_hit)   state_d = S_IDLE;
        else if (fall) state_d = (bit_cnt_q == 6'd39) ? S_CHECK : S_BIT_LOW;
      end
      S_CHECK:     state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    dht_oe          = (state_q == S_START_LOW);
    bus.busy        = (state_q != S_IDLE);
    bus.new_data    = (state_q == S_CHECK) && sum_ok;
    bus.chk_err     = (state_q == S_CHECK) && !sum_ok;
    bus.tmo_err     = tmo_hit;
    bus.data_valid  = valid_q;
    bus.sensor_data = data_q;
  end

  // Timebase, shift register and reading registers
  always_comb begin
    presc_d   = tick ? '0 : presc_q + 1'b1;
    us_d      = us_inc;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    if (state_d != state_q) begin
      presc_d = '0;
      us_d    = '0;
    end
    case (state_q)
      S_RESP_HIGH: begin
        shreg_d   = '0;
        bit_cnt_d = '0;
      end
      S_BIT_HIGH: begin
        if (fall && !tmo_hit) begin
          shreg_d   = {shreg_q[38:0], bit_val};
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      S_CHECK: begin
        if (sum_ok) begin
          data_d  = shreg_q[39:8];
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // Line idles high; starting the synchroniser high avoids a phantom edge.
      sync1_q     <= 1'b1;
      line_q      <= 1'b1;
      line_prev_q <= 1'b1;
      presc_q     <= '0;
      us_q        <= '0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      sync1_q     <= dht_in;
      line_q      <= sync1_q;
      line_prev_q <= line_q;
      presc_q     <= presc_d;
      us_q        <= us_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: tb/tb_dht11_reader.sv
module tb_dht11_reader;

  logic clk = 1'b0;
  always #125 clk = ~clk;   // 4 MHz: 4 cycles per microsecond

  logic rst_a, rst_b, model_low, model_abort, dht_line, oe_a, oe_b;
  int   model_bit;
  assign dht_line = ~(oe_a | oe_b | model_low);

  dht11_reader_if bus_a();
  dht11_reader_if bus_b();

  dht11_reader #(.CLK_FREQ(4000000), .START_LOW_US(100), .AUTO_PERIOD_US(0))
    dut_a (.clk(clk), .reset_n(rst_a), .dht_in(dht_line), .dht_oe(oe_a), .bus(bus_a));
  dht11_reader #(.CLK_FREQ(4000000), .START_LOW_US(100), .AUTO_PERIOD_US(1000))
    dut_b (.clk(clk), .reset_n(rst_b), .dht_in(dht_line), .dht_oe(oe_b), .bus(bus_b));

  typedef struct packed {
    logic [2:0]  kind;   // {new_data, chk_err, tmo_err}
    logic [31:0] data;
    logic        valid;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  mon_e;
  int   applied = 0;
  int   miscompares = 0;
  int   oe_rises_a = 0;
  int   oe_rises_b = 0;
  logic [31:0] cur_data;
  logic        cur_valid;

  always @(posedge oe_a) oe_rises_a <= oe_rises_a + 1;
  always @(posedge oe_b) oe_rises_b <= oe_rises_b + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_wait(input string name);
    applied++;
    miscompares++;
    $display("FAIL %s: wait bound expired, got no event, want event", name);
  endtask

  task automatic wait_us(input int n);
    repeat (n * 4) @(negedge clk);
  endtask

  // Behavioural DHT11: 20 us turnaround, 80/80 us response, 50 us bit-low.
  // stuck >= 0 holds the line low from that bit onward (for 350 us).
  task automatic sensor(input logic [39:0] bits, input int hi0, input int hi1, input int stuck);
    int n;
    n = 0;
    while (dht_line !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
    if (n >= 4000) begin fail_wait("model_host_pull"); return; end
    n = 0;
    while (dht_line !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
    if (n >= 4000) begin fail_wait("model_host_release"); return; end
    wait_us(20);
    model_low = 1'b1; wait_us(80);
    model_low = 1'b0; wait_us(80);
    for (int i = 0; i < 40; i++) begin
      if (model_abort) begin model_low = 1'b0; return; end
      model_bit = i;
      model_low = 1'b1; wait_us(50);
      if (i == stuck) begin wait_us(300); model_low = 1'b0; return; end
      model_low = 1'b0;
      wait_us(bits[39-i] ? hi1 : hi0);
    end
    model_low = 1'b1; wait_us(50);
    model_low = 1'b0;
  endtask

  task automatic pulse_start_a;
    @(negedge clk) bus_a.start = 1'b1;
    @(negedge clk) bus_a.start = 1'b0;
  endtask

  // Count consecutive negedges with dht_oe high; returns on the first low one.
  task automatic measure_oe(input bit use_b, output int len);
    int n;
    n = 0;
    while (!(use_b ? oe_b : oe_a) && n < 100) begin @(negedge clk); n++; end
    len = 0;
    while ((use_b ? oe_b : oe_a) && len < 2000) begin len++; @(negedge clk); end
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin fail_wait("scoreboard_drain"); exp_q.delete(); end
    repeat (3) @(negedge clk);
  endtask

  task automatic read_txn(input logic [39:0] bits, input int hi0, input int hi1,
                          input int stuck, input bit poke, input string tag);
    int len, r0;
    r0 = oe_rises_a;
    fork
      sensor(bits, hi0, hi1, stuck);
      begin
        pulse_start_a;
        measure_oe(1'b0, len);
        check32({tag, "_start_low_cycles"}, 32'(len), 32'd400);
        if (poke) begin
          repeat (200) @(negedge clk);
          pulse_start_a;
        end
      end
    join
    wait_drain(20000);
    check32({tag, "_start_low_count"}, 32'(oe_rises_a - r0), 32'd1);
  endtask

  task automatic push_ev(input logic [2:0] kind);
    ev_t e;
    e.kind  = kind;
    e.data  = cur_data;
    e.valid = cur_valid;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_flags"}, {26'd0, oe_a, bus_a.busy, bus_a.data_valid,
            bus_a.new_data, bus_a.chk_err, bus_a.tmo_err}, 32'd0);
    check32({tag, "_sensor_data"}, bus_a.sensor_data, 32'd0);
  endtask

  // Monitor: every result pulse pops one expected event.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_a === 1'b1 && (bus_a.new_data | bus_a.chk_err | bus_a.tmo_err) === 1'b1) begin
        if (exp_q.size() == 0) begin
          applied++;
          miscompares++;
          $display("FAIL unexpected_event: got kind %b, want no event",
                   {bus_a.new_data, bus_a.chk_err, bus_a.tmo_err});
        end else begin
          mon_e = exp_q.pop_front();
          check32("event_kind", {29'd0, bus_a.new_data, bus_a.chk_err, bus_a.tmo_err},
                  {29'd0, mon_e.kind});
          @(posedge clk); #1;
          check32("sensor_data", bus_a.sensor_data, mon_e.data);
          check32("data_valid", {31'd0, bus_a.data_valid}, {31'd0, mon_e.valid});
          check32("busy_after_result", {31'd0, bus_a.busy}, 32'd0);
        end
      end
    end
  end

  initial begin
    #(95000 * 250);
    $display("FAIL watchdog: got no end of run, want end before 95000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, len, idle, rb0;
    rst_a = 1'b0; rst_b = 1'b0; model_low = 1'b0; model_abort = 1'b0; model_bit = -1;
    bus_a.start = 1'b0; bus_b.start = 1'b0;
    cur_data = 32'd0; cur_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_a = 1'b1;
    repeat (5) @(negedge clk);

    // 1: good reading, plus a start pulse while busy
    cur_data = 32'h37001900; cur_valid = 1'b1; push_ev(3'b100);
    read_txn(40'h3700190050, 27, 70, -1, 1'b1, "good");

    // 2: bad checksum
    push_ev(3'b010);
    read_txn(40'h3700190051, 27, 70, -1, 1'b0, "badsum");

    // 3a: no response -> timeout 200 us after START_LOW ends
    push_ev(3'b001);
    rb0 = oe_rises_a;
    pulse_start_a;
    measure_oe(1'b0, len);
    check32("noresp_start_low_cycles", 32'(len), 32'd400);
    n = 1;
    while (!bus_a.tmo_err && n < 2000) begin @(negedge clk); n++; end
    check32("noresp_tmo_cycle", 32'(n), 32'd800);
    wait_drain(2000);
    check32("noresp_start_low_count", 32'(oe_rises_a - rb0), 32'd1);

    // 3b: line stuck low from bit 12
    push_ev(3'b001);
    read_txn(40'h3700190050, 27, 70, 12, 1'b0, "stuck");

    // 4: checksum wraps mod 256; 47 us high -> 0, 49 us high -> 1
    cur_data = 32'hFFFF0102; push_ev(3'b100);
    read_txn(40'hFFFF010201, 47, 49, -1, 1'b0, "wrap");

    // 5a: reset during START_LOW
    pulse_start_a;
    repeat (50) @(negedge clk);
    check32("pre_reset_oe", {31'd0, oe_a}, 32'd1);
    rst_a = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("rst_start_low");
    @(negedge clk) rst_a = 1'b1;
    cur_data = 32'd0; cur_valid = 1'b0;
    repeat (10) @(negedge clk);

    // 5b: reset during BIT_HIGH (bit 5 of 0x37 is a 70 us one)
    fork
      sensor(40'h3700190050, 27, 70, -1);
      begin
        pulse_start_a;
        n = 0;
        while (!(model_bit == 5 && model_low == 1'b0) && n < 30000) begin @(negedge clk); n++; end
        if (n >= 30000) fail_wait("reach_bit5");
        repeat (40) @(negedge clk);
        check32("pre_reset_busy", {31'd0, bus_a.busy}, 32'd1);
        rst_a = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("rst_bit_high");
        model_abort = 1'b1;
        @(negedge clk) rst_a = 1'b1;
      end
    join
    model_abort = 1'b0;
    wait_drain(100);

    // 6: automatic reads on dut_b, start collides with the auto expiry
    @(negedge clk) rst_b = 1'b1;
    n = 0;
    while (!bus_b.busy && n < 6000) begin @(negedge clk); n++; end
    if (n >= 6000) fail_wait("auto_first_read");
    n = 0;
    while (bus_b.busy && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) fail_wait("auto_first_idle");
    rb0 = oe_rises_b;
    idle = 0;
    while (!bus_b.busy && idle < 6000) begin
      idle++;
      if (idle == 4000) bus_b.start = 1'b1;
      @(negedge clk);
      bus_b.start = 1'b0;
    end
    check32("auto_gap_cycles", 32'(idle), 32'd4000);
    measure_oe(1'b1, len);
    check32("auto_start_low_cycles", 32'(len), 32'd400);
    n = 0;
    while (bus_b.busy && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) fail_wait("auto_second_idle");
    check32("collision_start_low_count", 32'(oe_rises_b - rb0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
